axi_tensor_rd_slave: RTL



---
 rtl/axi_tensor_rd_slave_if.sv | 32 +++
 rtl/axi_tensor_rd_slave.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/axi_tensor_rd_slave_if.sv
// AR/R channel bundle between a tensorcore AXI read master and the read slave.
`timescale 1ns/1ps
interface axi_tensor_rd_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256
);
  logic [ADDR_WIDTH-1:0] s_axi_araddr;
  logic [7:0]            s_axi_arlen;
  logic [2:0]            s_axi_arsize;
  logic [1:0]            s_axi_arburst;
  logic                  s_axi_arvalid;
  logic                  s_axi_arready;
  logic [DATA_WIDTH-1:0] s_axi_rdata;
  logic [1:0]            s_axi_rresp;
  logic                  s_axi_rlast;
  logic                  s_axi_rvalid;
  logic                  s_axi_rready;

  modport master (
    output s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
    input  s_axi_arready,
    input  s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
    output s_axi_rready
  );

  modport slave (
    input  s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
    output s_axi_arready,
    output s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
    input  s_axi_rready
  );
endinterface

// File: rtl/axi_tensor_rd_slave.sv
// AXI4 read-only slave over a preloadable word memory; answers AR bursts with
// registered R beats, SLVERR for words beyond the memory.
`timescale 1ns/1ps
module axi_tensor_rd_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256,
  parameter int MEM_DEPTH  = 1024,
  localparam int MEM_AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  axi_tensor_rd_slave_if.slave  s_axi,
  input  logic                  mem_wr_en,
  input  logic [MEM_AW-1:0]     mem_wr_addr,
  input  logic [DATA_WIDTH-1:0] mem_wr_data
);
  localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);

  typedef enum logic {IDLE, BURST} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [2:0]            size_q, size_d;
  logic                  fixed_q, fixed_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rlast_q, rlast_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  ar_fire;
  logic                  r_fire;
  logic                  load_en;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic [ADDR_WIDTH-1:0] load_idx;
  logic [7:0]            load_cnt;
  logic [7:0]            load_len;
  logic                  load_in_range;
  logic [DATA_WIDTH-1:0] load_word;

  assign ar_fire   = (state_q == IDLE) && s_axi.s_axi_arvalid && arready_q;
  assign r_fire    = (state_q == BURST) && rvalid_q && s_axi.s_axi_rready;
  assign next_addr = fixed_q ? addr_q : addr_q + (ADDR_WIDTH'(1) << size_q);

  // Beat 0 comes from the AR request itself; later beats from the advanced address.
  assign load_en       = ar_fire || (r_fire && !rlast_q);
  assign load_addr     = ar_fire ? s_axi.s_axi_araddr : next_addr;
  assign load_cnt      = ar_fire ? 8'd0 : cnt_q + 8'd1;
  assign load_len      = ar_fire ? s_axi.s_axi_arlen : len_q;
  assign load_idx      = load_addr >> BYTE_SHIFT;
  assign load_in_range = load_idx < ADDR_WIDTH'(MEM_DEPTH);
  assign load_word     = mem[load_idx[MEM_AW-1:0]];

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    size_d    = size_q;
    fixed_d   = fixed_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;

    unique case (state_q)
      IDLE: begin
        arready_d = 1'b1;
        if (ar_fire) begin
          state_d   = BURST;
          arready_d = 1'b0;
          addr_d    = s_axi.s_axi_araddr;
          len_d     = s_axi.s_axi_arlen;
          size_d    = s_axi.s_axi_arsize;
          fixed_d   = (s_axi.s_axi_arburst == 2'b00);
          cnt_d     = 8'd0;
        end
      end
      BURST: begin
        if (r_fire) begin
          if (rlast_q) begin
            state_d   = IDLE;
            arready_d = 1'b1;
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
          end else begin
            addr_d = next_addr;
            cnt_d  = load_cnt;
          end
        end
      end
    endcase

    if (load_en) begin
      rvalid_d = 1'b1;
      rdata_d  = load_in_range ? load_word : '0;
      rresp_d  = load_in_range ? 2'b00 : 2'b10;
      rlast_d  = (load_cnt == load_len);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      size_q    <= '0;
      fixed_q   <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      size_q    <= size_d;
      fixed_q   <= fixed_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // Contents survive reset; a same-edge write is invisible to the beat loaded on that edge.
  always_ff @(posedge aclk) begin
    if (mem_wr_en) begin
      mem[mem_wr_addr] <= mem_wr_data;
    end
  end

  assign s_axi.s_axi_arready = arready_q;
  assign s_axi.s_axi_rvalid  = rvalid_q;
  assign s_axi.s_axi_rlast   = rlast_q;
  assign s_axi.s_axi_rdata   = rdata_q;
  assign s_axi.s_axi_rresp   = rresp_q;
endmodule
